// File: rtl/bcd_clock_counter.sv
// Real-time clock counter in packed BCD, advanced by a 1 Hz tick that arrives asynchronously to clk.
// Supports 24-hour (00-23) or 12-hour (01-12) hour counting and validated time loads.
module bcd_clock_counter #(
    parameter bit H24 = 1'b1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       tick_in,
    input  logic       run,
    input  logic       load,
    input  logic [7:0] load_hh,
    input  logic [7:0] load_mm,
    input  logic [7:0] load_ss,
    output logic [7:0] hh,
    output logic [7:0] mm,
    output logic [7:0] ss,
    output logic       sec_pulse,
    output logic       min_pulse,
    output logic       hour_pulse,
    output logic       load_err
);

    localparam logic [7:0] HH_RESET = H24 ? 8'h00 : 8'h12;

    logic       t1_q, t2_q, t3_q;
    logic [7:0] hh_q, mm_q, ss_q, hh_d, mm_d, ss_d;
    logic       sec_q, min_q, hour_q, err_q;
    logic       sec_d, min_d, hour_d, err_d;
    logic       tick_edge;
    logic       load_ok;
    logic [7:0] hh_next;

    function automatic logic [7:0] bcd_inc(input logic [7:0] v);
        if (v[3:0] == 4'd9)
            return {v[7:4] + 4'd1, 4'd0};
        else
            return {v[7:4], v[3:0] + 4'd1};
    endfunction

    function automatic logic nibbles_ok(input logic [7:0] v);
        return (v[7:4] <= 4'd9) && (v[3:0] <= 4'd9);
    endfunction

    assign tick_edge = t2_q & ~t3_q;

    assign load_ok = nibbles_ok(load_hh) && nibbles_ok(load_mm) && nibbles_ok(load_ss)
                  && (load_ss <= 8'h59) && (load_mm <= 8'h59)
                  && (H24 ? (load_hh <= 8'h23)
                          : ((load_hh >= 8'h01) && (load_hh <= 8'h12)));

    // 12-hour mode never shows 00: 12 is followed by 01.
    always_comb begin
        if (H24)
            hh_next = (hh_q == 8'h23) ? 8'h00 : bcd_inc(hh_q);
        else
            hh_next = (hh_q == 8'h12) ? 8'h01 : bcd_inc(hh_q);
    end

    always_comb begin
        // NOTE: every output of this block is given a default first so no path leaves it unassigned (no latch).
        hh_d   = hh_q;
        mm_d   = mm_q;
        ss_d   = ss_q;
        sec_d  = 1'b0;
        min_d  = 1'b0;
        hour_d = 1'b0;
        err_d  = 1'b0;
        if (load) begin
            if (load_ok) begin
                hh_d = load_hh;
                mm_d = load_mm;
                ss_d = load_ss;
            end else begin
                err_d = 1'b1;
            end
        end else if (tick_edge && run) begin
            sec_d = 1'b1;
            if (ss_q == 8'h59) begin
                ss_d  = 8'h00;
                min_d = 1'b1;
                if (mm_q == 8'h59) begin
                    mm_d   = 8'h00;
                    hour_d = 1'b1;
                    hh_d   = hh_next;
                end else begin
                    mm_d = bcd_inc(mm_q);
                end
            end else begin
                ss_d = bcd_inc(ss_q);
            end
        end
    end

    // NOTE: reset is synchronous (only sampled on clk), and all state uses non-blocking assignments.
    always_ff @(posedge clk) begin
        if (!rst) begin
            t1_q   <= 1'b1;
            t2_q   <= 1'b1;
            t3_q   <= 1'b1;
            hh_q   <= HH_RESET;
            mm_q   <= 8'h00;
            ss_q   <= 8'h00;
            sec_q  <= 1'b0;
            min_q  <= 1'b0;
            hour_q <= 1'b0;
            err_q  <= 1'b0;
        end else begin
            t1_q   <= tick_in;
            t2_q   <= t1_q;
            t3_q   <= t2_q;
            hh_q   <= hh_d;
            mm_q   <= mm_d;
            ss_q   <= ss_d;
            sec_q  <= sec_d;
            min_q  <= min_d;
            hour_q <= hour_d;
            err_q  <= err_d;
        end
    end

    assign hh         = hh_q;
    assign mm         = mm_q;
    assign ss         = ss_q;
    assign sec_pulse  = sec_q;
    assign min_pulse  = min_q;
    assign hour_pulse = hour_q;
    assign load_err   = err_q;

endmodule
